// File: rtl/complex_pkg.sv
// complex_pkg: shared helpers for the complex-arithmetic blocks.
//   A complex word of width EW holds real in [EW-1:EW/2] and imag in
//   [EW/2-1:0], both two's complement. The helpers work on a CMAX_W-wide
//   container word. The half width is passed as an argument, so any block
//   with EW <= CMAX_W can use them. Every component result wraps modulo
//   2^hw.
package complex_pkg;

    localparam int ELEMENT_WIDTH = 64;
    localparam int CMAX_W        = 128;

    typedef logic [CMAX_W-1:0] cword_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Low hw bits set.
    function automatic cword_t hmask(input int hw);
        cword_t m;
        m = '0;
        for (int i = 0; i < CMAX_W / 2; i++) begin
            if (i < hw) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic cword_t re(input cword_t x, input int hw);
        return (x >> hw) & hmask(hw);
    endfunction

    function automatic cword_t im(input cword_t x, input int hw);
        return x & hmask(hw);
    endfunction

    function automatic cword_t cpack(input cword_t r, input cword_t i, input int hw);
        return ((r & hmask(hw)) << hw) | (i & hmask(hw));
    endfunction

    function automatic cword_t cadd(input cword_t a, input cword_t b, input int hw);
        return cpack(re(a, hw) + re(b, hw), im(a, hw) + im(b, hw), hw);
    endfunction

    // Negating the most negative component wraps back to itself.
    function automatic cword_t cneg(input cword_t a, input int hw);
        return cpack(~re(a, hw) + cword_t'(1), ~im(a, hw) + cword_t'(1), hw);
    endfunction

endpackage

// File: rtl/complex_row_accumulator_if.sv
// complex_row_accumulator_if: row-in / sum-out bundle.
//   master : drives in_valid/in_last/in_sub/in_row and observes results.
//   slave  : the accumulator. It samples rows and drives out_valid/out_sum/out_rows.
interface complex_row_accumulator_if #(
    parameter int NI    = 8,
    parameter int EW    = 64,
    parameter int CNT_W = 16
) ();
    logic                 in_valid;
    logic                 in_last;
    logic                 in_sub;
    logic [NI*EW-1:0]     in_row;
    logic                 out_valid;
    logic [EW-1:0]        out_sum;
    logic [CNT_W-1:0]     out_rows;

    modport master (
        output in_valid, in_last, in_sub, in_row,
        input  out_valid, out_sum, out_rows
    );

    modport slave (
        input  in_valid, in_last, in_sub, in_row,
        output out_valid, out_sum, out_rows
    );
endinterface

// File: rtl/complex_adder_tree.sv
// complex_adder_tree: pipelined reduction of NI complex lanes to one sum.
//   The first register stage captures the row. Each of the following
//   log2(NI) stages adds lane pairs component-wise. valid/last/sub travel
//   in a matching shift register. last and sub are qualified with valid on
//   entry. Result appears L+1 edges after the row is sampled.
//   Ports: clk, rst_n (async low), in_valid/in_last/in_sub/in_row (row in),
//          out_valid/out_last/out_sub/out_sum (reduced row out).
module complex_adder_tree #(
    parameter int NI = 8,
    parameter int EW = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_sub,
    input  logic [NI*EW-1:0] in_row,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_sub,
    output logic [EW-1:0]    out_sum
);
    import complex_pkg::*;

    localparam int L  = clog2(NI);
    localparam int HN = NI / 2;

    logic [NI-1:0][EW-1:0]         row_q;
    logic [L-1:0][HN-1:0][EW-1:0]  tr, tr_nxt;
    logic [L:0]                    vld_pipe, last_pipe, sub_pipe;

    // Stage s keeps NI>>(s+1) live lanes. The upper lanes stay zero.
    // The modulo terms only keep dead-lane indices in range.
    always_comb begin
        tr_nxt = '0;
        for (int s = 0; s < L; s++) begin
            for (int j = 0; j < HN; j++) begin
                if (j < (NI >> (s + 1))) begin
                    if (s == 0) begin
                        tr_nxt[s][j] = EW'(cadd(cword_t'(row_q[2*j]),
                                                cword_t'(row_q[2*j+1]), EW / 2));
                    end else begin
                        tr_nxt[s][j] = EW'(cadd(cword_t'(tr[(s > 0) ? s - 1 : 0][(2*j) % HN]),
                                                cword_t'(tr[(s > 0) ? s - 1 : 0][(2*j+1) % HN]),
                                                EW / 2));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            tr        <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            sub_pipe  <= '0;
        end else begin
            row_q     <= in_row;
            tr        <= tr_nxt;
            vld_pipe  <= {vld_pipe[L-1:0],  in_valid};
            last_pipe <= {last_pipe[L-1:0], in_valid & in_last};
            sub_pipe  <= {sub_pipe[L-1:0],  in_valid & in_sub};
        end
    end

    assign out_valid = vld_pipe[L];
    assign out_last  = last_pipe[L];
    assign out_sub   = sub_pipe[L];
    assign out_sum   = tr[L-1][0];

endmodule

// File: rtl/complex_row_accumulator.sv
// complex_row_accumulator: accumulates reduced rows into one complex sum
// per vector, framed by in_last.
//   Ports: clk, rst_n (async low), bus (slave modport):
//     in_valid/in_last/in_sub/in_row -> row per cycle, no backpressure
//     out_valid pulse with out_sum (vector sum) and out_rows (saturating
//     row count). Both outputs hold between pulses.
module complex_row_accumulator #(
    parameter int NI            = 8,
    parameter int ELEMENT_WIDTH = complex_pkg::ELEMENT_WIDTH,
    parameter int CNT_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    complex_row_accumulator_if.slave  bus
);
    import complex_pkg::*;

    localparam int EW = ELEMENT_WIDTH;

    logic             t_vld, t_last, t_sub;
    logic [EW-1:0]    t_sum;

    complex_adder_tree #(.NI(NI), .EW(EW)) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_last   (bus.in_last),
        .in_sub    (bus.in_sub),
        .in_row    (bus.in_row),
        .out_valid (t_vld),
        .out_last  (t_last),
        .out_sub   (t_sub),
        .out_sum   (t_sum)
    );

    logic [EW-1:0]    acc, val, acc_nxt, sum_q;
    logic [CNT_W-1:0] cnt, cnt_nxt, rows_q;
    logic             first, vld_q;

    // On the first row of a vector the stale acc is replaced, not added to.
    always_comb begin
        val     = t_sub ? EW'(cneg(cword_t'(t_sum), EW / 2)) : t_sum;
        acc_nxt = first ? val : EW'(cadd(cword_t'(acc), cword_t'(val), EW / 2));
        cnt_nxt = first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            first  <= 1'b1;
            vld_q  <= 1'b0;
            sum_q  <= '0;
            rows_q <= '0;
        end else begin
            vld_q <= 1'b0;
            if (t_vld) begin
                acc   <= acc_nxt;
                cnt   <= cnt_nxt;
                first <= t_last;
                if (t_last) begin
                    vld_q  <= 1'b1;
                    sum_q  <= acc_nxt;
                    rows_q <= cnt_nxt;
                end
            end
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_rows  = rows_q;

endmodule

// File: doc/complex_row_accumulator.md
# complex_row_accumulator

Parametrised, pipelined complex-vector accumulator: reduces an NI-lane row of complex elements per cycle through a registered adder tree and accumulates successive rows into one complex sum per vector, framed by `in_last`. It replaces the fixed 8-lane organiser with its delay-line control in the matrix-vector datapath. It adds valid/last framing, per-row add/subtract, gap tolerance and a row counter, and needs no external delay chain.

## Interface
- `NI`, 8: lanes per row; power of two, ≥2.
- `ELEMENT_WIDTH`, 64: bits per complex element; real = `[EW-1:EW/2]`, imag = `[EW/2-1:0]`, each two's complement.
- `CNT_W`, 16: width of the row counter.
- `clk` in 1: clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: row present this cycle.
- `in_last` in 1: row closes the current vector; qualified by `in_valid`.
- `in_sub` in 1: row is subtracted from, not added to, the sum; qualified by `in_valid`.
- `in_row` in NI*EW: lane i at `[i*EW +: EW]`.
- `out_valid` out 1: one-cycle pulse; `out_sum` and `out_rows` are valid.
- `out_sum` out EW: complex vector sum.
- `out_rows` out CNT_W: rows in the vector; saturates at all-ones.

## Operation
- Tree: log2(NI) register stages (L). Each stage adds lane pairs component-wise. `in_valid`, `in_last` and `in_sub` ride alongside as sideband.
- Arithmetic: real and imag are independent. Sums wrap modulo 2^(EW/2) with no saturation or overflow flag.
- Subtract: two's complement negation of the tree result on each component before accumulation. Negating the most negative value wraps to itself.
- Accumulator stage, on a valid tree output:
  - If this is the first row of a vector: acc = ±tree, cnt = 1.
  - Otherwise: acc = acc ± tree, cnt = cnt+1, saturating.
  - On the first row of a vector, the previous acc is discarded; it is not added.
- `first` flag: set at reset and after every last row, cleared by any other valid row.
- Last row: `out_sum` gets the final acc value including this row, `out_rows` gets the final count, and `out_valid` pulses. `first` is set.
- Back-to-back vectors: a row following a last row on the next cycle starts a new vector with no bubble.
- Single-row vector (first and last): `out_sum` = ±row sum, `out_rows` = 1.
- Gaps (`in_valid`=0): the pipeline advances. acc, cnt and `first` hold. Any number of gaps may occur inside a vector.
- `in_last` or `in_sub` with `in_valid`=0: ignored.
- No backpressure: one row is accepted every cycle `in_valid` is high.

## Timing
- Latency: a row sampled at edge t affects acc at edge t+L+1. For a last row, `out_valid` is high in the cycle after edge t+L+1; for NI=8 that is 4 cycles.
- Throughput: 1 row/cycle; 1 result per vector.
- Between pulses, `out_sum` and `out_rows` hold their last values.
- Reset values:
  - `out_valid`=0, `out_sum`=0, `out_rows`=0.
  - acc and cnt = 0, `first`=1.
  - All tree data and sideband registers = 0.
- Reset mid-vector: partial sums and in-flight rows are discarded. No `out_valid` follows reset until a new last row has propagated.
- Deassertion of `rst_n` is synchronous to `clk` at the system level; the block does not resynchronise it.

## Structure
- Package `complex_pkg`:
  - `ELEMENT_WIDTH` default and the `re()`/`im()` field extractors.
  - `cadd`, `cneg` functions.
  - `clog2` constant function.
  - Shared with the other complex blocks.
- Sub-module `complex_adder_tree`:
  - Parameters NI and EW.
  - Pipelined reduction with a valid/last/sub sideband pipe.
  - Reset as above.
- Top: accumulator, `first` flag, counter and output registers.

## Test plan
- Single-row vector, NI=8: all lanes = (1,2), `in_last`=1 → 4 cycles later `out_valid`=1, `out_sum`=(8,16), `out_rows`=1.
- Three rows back-to-back:
  - Stimulus: lanes (1,1), then (2,−1), then (3,0) with `in_sub`=1 and `in_last` on the third row.
  - Response: `out_sum`=(0,0), `out_rows`=3.
  - A further vector starting the very next cycle, lanes (1,0) with `in_last`, gives (8,0), 1.
- Gaps: the same three rows separated by 2 idle cycles each give the identical result. `out_valid` is asserted exactly once, L+1 cycles after the last row.
- Wrap: EW=64, NI=2, lanes real=0x7FFFFFFF and 1 → real=0x80000000.
  - Negating 0x80000000 with `in_sub` gives 0x80000000.
- Reset mid-vector: two rows issued, `rst_n` pulsed low for 1 cycle, then a single last row of (1,1) lanes.
  - Response: `out_sum`=(8,8), `out_rows`=1.
  - No spurious `out_valid` and all outputs at 0 during reset.
- Counter saturation: CNT_W=2, 5 rows then last → `out_rows`=3.
